// File: rtl/uart_tx_if.sv
// Parallel-side handshake and status bundle for the UART transmitter.
// The host drives the word and valid; the transmitter returns ready,
// the serial line and its busy/done status.
interface uart_tx_if #(
   parameter int BUS_WIDTH = 8
);
   logic [BUS_WIDTH-1:0] i_tx_bus;
   logic                 i_tx_valid;
   logic                 o_tx_ready;
   logic                 o_tx_serial;
   logic                 o_tx_active;
   logic                 o_tx_done;

   modport master (
      output i_tx_bus,
      output i_tx_valid,
      input  o_tx_ready,
      input  o_tx_serial,
      input  o_tx_active,
      input  o_tx_done
   );

   modport slave (
      input  i_tx_bus,
      input  i_tx_valid,
      output o_tx_ready,
      output o_tx_serial,
      output o_tx_active,
      output o_tx_done
   );
endinterface

// File: rtl/uart_tx.sv
// UART transmitter: start bit, BUS_WIDTH data bits LSB first, optional
// parity bit and one or two stop bits. Every output is a flop so the TX
// pin never sees combinational glitches.
module uart_tx #(
   parameter int BAUD_RATE   = 115200,
   parameter int CLK_FREQ    = 300000000,
   parameter int BUS_WIDTH   = 8,
   parameter int PARITY      = 0,
   parameter int STOP_BITS   = 1,
   parameter int CLK_PER_BIT = CLK_FREQ / BAUD_RATE
) (
   input logic      i_clk,
   input logic      i_rst_n,
   uart_tx_if.slave tx
);

   localparam int CNT_W = (CLK_PER_BIT > 2) ? $clog2(CLK_PER_BIT) : 1;
   localparam int IDX_W = (BUS_WIDTH > 1) ? $clog2(BUS_WIDTH) : 1;
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLK_PER_BIT - 1);
   localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(BUS_WIDTH - 1);
   localparam bit HAS_PARITY = (PARITY == 1) || (PARITY == 2);
   localparam bit EVEN_PARITY = (PARITY == 2);
   localparam bit LAST_STOP = (STOP_BITS == 2);

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_START,
      ST_DATA,
      ST_PARITY,
      ST_STOP
   } state_t;

   state_t               state;
   logic [CNT_W-1:0]     bit_cnt;
   logic [IDX_W-1:0]     bit_idx;
   logic [IDX_W-1:0]     next_idx;
   logic [BUS_WIDTH-1:0] shift_reg;
   logic                 parity_bit;
   logic                 stop_idx;
   logic                 cnt_wrap;
   logic                 serial;
   logic                 ready;
   logic                 active;
   logic                 done;

   assign cnt_wrap = (bit_cnt == CNT_LAST);
   assign next_idx = bit_idx + IDX_W'(1);

   assign tx.o_tx_serial = serial;
   assign tx.o_tx_ready  = ready;
   assign tx.o_tx_active = active;
   assign tx.o_tx_done   = done;

   // Frame sequencer: bit timing counter, state walk and registered line/status outputs
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         state      <= ST_IDLE;
         bit_cnt    <= '0;
         bit_idx    <= '0;
         shift_reg  <= '0;
         parity_bit <= 1'b0;
         stop_idx   <= 1'b0;
         serial     <= 1'b1;
         ready      <= 1'b1;
         active     <= 1'b0;
         done       <= 1'b0;
      end else begin
         done <= 1'b0;
         if (state != ST_IDLE) begin
            bit_cnt <= cnt_wrap ? '0 : bit_cnt + CNT_W'(1);
         end
         case (state)
            ST_IDLE: begin
               serial  <= 1'b1;
               ready   <= 1'b1;
               active  <= 1'b0;
               bit_cnt <= '0;
               if (tx.i_tx_valid && ready) begin
                  shift_reg  <= tx.i_tx_bus;
                  parity_bit <= EVEN_PARITY ? (^tx.i_tx_bus) : ~(^tx.i_tx_bus);
                  state      <= ST_START;
                  serial     <= 1'b0;
                  ready      <= 1'b0;
                  active     <= 1'b1;
               end
            end
            ST_START: begin
               if (cnt_wrap) begin
                  bit_idx <= '0;
                  serial  <= shift_reg[0];
                  state   <= ST_DATA;
               end
            end
            ST_DATA: begin
               if (cnt_wrap) begin
                  if (bit_idx == IDX_LAST) begin
                     bit_idx <= '0;
                     if (HAS_PARITY) begin
                        serial <= parity_bit;
                        state  <= ST_PARITY;
                     end else begin
                        serial   <= 1'b1;
                        stop_idx <= 1'b0;
                        state    <= ST_STOP;
                     end
                  end else begin
                     bit_idx <= next_idx;
                     serial  <= shift_reg[next_idx];
                  end
               end
            end
            ST_PARITY: begin
               if (cnt_wrap) begin
                  serial   <= 1'b1;
                  stop_idx <= 1'b0;
                  state    <= ST_STOP;
               end
            end
            ST_STOP: begin
               serial <= 1'b1;
               if (cnt_wrap) begin
                  if (stop_idx == LAST_STOP) begin
                     state  <= ST_IDLE;
                     ready  <= 1'b1;
                     active <= 1'b0;
                     done   <= 1'b1;
                  end else begin
                     stop_idx <= 1'b1;
                  end
               end
            end
            default: begin
               state  <= ST_IDLE;
               serial <= 1'b1;
               ready  <= 1'b1;
               active <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_uart_tx.sv
// Self-checking bench for uart_tx. Four transmitters share clock and reset:
// 0 = no parity/1 stop, 1 = even parity, 2 = odd parity, 3 = 2 stop bits.
// Each runs at 16 clocks per bit; line samples are taken at bit centres.
module tb_uart_tx;

   localparam int NDUT = 4;
   localparam int CAPN = 400;

   logic clk;
   logic rst_n;

   logic [7:0] bus_drv [NDUT];
   logic       valid_drv [NDUT];
   logic       ser_mon [NDUT];
   logic       ready_mon [NDUT];
   logic       active_mon [NDUT];
   logic       done_mon [NDUT];

   logic cap_serial [0:CAPN-1];
   logic cap_ready [0:CAPN-1];
   logic cap_active [0:CAPN-1];
   logic cap_done [0:CAPN-1];

   int checks;
   int errors;

   typedef struct {
      int          sel;
      logic [7:0]  data;
      logic [0:10] exp_bits;
      int          nbits;
      int          done_at;
   } vec_t;

   vec_t vecs [5];

   // Free-running 10 ns clock
   initial clk = 1'b0;
   always #5 clk = ~clk;

   for (genvar g = 0; g < NDUT; g++) begin : g_dut
      uart_tx_if #(.BUS_WIDTH(8)) bus_if ();

      assign bus_if.i_tx_bus   = bus_drv[g];
      assign bus_if.i_tx_valid = valid_drv[g];
      assign ser_mon[g]        = bus_if.o_tx_serial;
      assign ready_mon[g]      = bus_if.o_tx_ready;
      assign active_mon[g]     = bus_if.o_tx_active;
      assign done_mon[g]       = bus_if.o_tx_done;

      uart_tx #(
         .BAUD_RATE (100000),
         .CLK_FREQ  (1600000),
         .BUS_WIDTH (8),
         .PARITY    ((g == 1) ? 2 : ((g == 2) ? 1 : 0)),
         .STOP_BITS ((g == 3) ? 2 : 1)
      ) dut (
         .i_clk   (clk),
         .i_rst_n (rst_n),
         .tx      (bus_if)
      );
   end

   task automatic checkBit(input string name, input logic actual, input logic expected);
      checks++;
      if (actual !== expected) begin
         errors++;
         $display("[TB] FAIL %s: got %b expected %b", name, actual, expected);
      end
   endtask

   task automatic checkInt(input string name, input int actual, input int expected);
      checks++;
      if (actual != expected) begin
         errors++;
         $display("[TB] FAIL %s: got %0d expected %0d", name, actual, expected);
      end
   endtask

   // Presents one word and records ncyc cycles of outputs; k = 1 is the cycle after accept
   task automatic applyStimulus(input int sel, input logic [7:0] data, input logic [7:0] data2,
                                input int change_at, input int drop_at, input int pulse_at,
                                input int ncyc);
      @(negedge clk);
      checkBit($sformatf("dut%0d_ready_before_accept", sel), ready_mon[sel], 1'b1);
      bus_drv[sel]   = data;
      valid_drv[sel] = 1'b1;
      for (int k = 1; k <= ncyc; k++) begin
         @(negedge clk);
         cap_serial[k] = ser_mon[sel];
         cap_ready[k]  = ready_mon[sel];
         cap_active[k] = active_mon[sel];
         cap_done[k]   = done_mon[sel];
         if (k == change_at) bus_drv[sel] = data2;
         if (k == drop_at) valid_drv[sel] = 1'b0;
         if (pulse_at != 0 && k == pulse_at) valid_drv[sel] = 1'b1;
         if (pulse_at != 0 && k == pulse_at + 2) valid_drv[sel] = 1'b0;
      end
      valid_drv[sel] = 1'b0;
   endtask

   // Compares a captured frame starting at offset+1 against its expected bit pattern
   task automatic checkOutput(input string tag, input logic [0:10] exp_bits, input int nbits,
                              input int offset, input int done_at);
      int ready_hi;
      int active_lo;
      ready_hi  = 0;
      active_lo = 0;
      for (int j = 0; j < nbits; j++) begin
         checkBit($sformatf("%s_bit%0d", tag, j), cap_serial[offset + 8 + 16 * j], exp_bits[j]);
      end
      for (int k = offset + 1; k < offset + done_at; k++) begin
         if (cap_ready[k] !== 1'b0) ready_hi++;
         if (cap_active[k] !== 1'b1) active_lo++;
      end
      checkInt({tag, "_ready_low_in_frame"}, ready_hi, 0);
      checkInt({tag, "_active_high_in_frame"}, active_lo, 0);
      checkBit({tag, "_done_pulse"}, cap_done[offset + done_at], 1'b1);
      checkBit({tag, "_ready_at_done"}, cap_ready[offset + done_at], 1'b1);
      checkBit({tag, "_active_at_done"}, cap_active[offset + done_at], 1'b0);
   endtask

   function automatic int countDone(input int ncyc);
      int n;
      n = 0;
      for (int k = 1; k <= ncyc; k++) begin
         if (cap_done[k] === 1'b1) n++;
      end
      return n;
   endfunction

   task automatic runVector(input int i);
      int ncyc;
      ncyc = vecs[i].done_at + 20;
      applyStimulus(vecs[i].sel, vecs[i].data, vecs[i].data, 0, 1, 0, ncyc);
      checkOutput($sformatf("v%0d", i), vecs[i].exp_bits, vecs[i].nbits, 0, vecs[i].done_at);
      checkInt($sformatf("v%0d_done_count", i), countDone(ncyc), 1);
   endtask

   initial begin
      int cnt;
      int done_seen;
      checks = 0;
      errors = 0;
      rst_n  = 1'b0;
      for (int d = 0; d < NDUT; d++) begin
         bus_drv[d]   = 8'h00;
         valid_drv[d] = 1'b0;
      end

      // Hand-computed frames: index j of exp_bits is the j-th bit-centre sample
      vecs[0] = '{sel: 0, data: 8'hA5, exp_bits: 11'b01010010110, nbits: 10, done_at: 161};
      vecs[1] = '{sel: 1, data: 8'h07, exp_bits: 11'b01110000011, nbits: 11, done_at: 177};
      vecs[2] = '{sel: 2, data: 8'h07, exp_bits: 11'b01110000001, nbits: 11, done_at: 177};
      vecs[3] = '{sel: 3, data: 8'h3C, exp_bits: 11'b00011110011, nbits: 11, done_at: 177};
      vecs[4] = '{sel: 0, data: 8'h81, exp_bits: 11'b01000000110, nbits: 10, done_at: 161};

      repeat (3) @(negedge clk);
      for (int d = 0; d < NDUT; d++) begin
         checkBit($sformatf("dut%0d_reset_serial", d), ser_mon[d], 1'b1);
         checkBit($sformatf("dut%0d_reset_ready", d), ready_mon[d], 1'b1);
         checkBit($sformatf("dut%0d_reset_active", d), active_mon[d], 1'b0);
         checkBit($sformatf("dut%0d_reset_done", d), done_mon[d], 1'b0);
      end
      rst_n = 1'b1;
      repeat (2) @(negedge clk);

      $display("[TB] single frames across parity and stop configurations");
      for (int i = 0; i < 4; i++) begin
         runVector(i);
         if (vecs[i].sel == 3) begin
            cnt = 0;
            for (int k = 145; k <= 176; k++) begin
               if (cap_serial[k] !== 1'b1) cnt++;
            end
            checkInt("stop2_line_high_32", cnt, 0);
         end
      end

      $display("[TB] back-to-back 0x00 then 0xFF with valid held");
      applyStimulus(0, 8'h00, 8'hFF, 1, 322, 0, 340);
      checkOutput("b2b_first", 11'b00000000010, 10, 0, 161);
      checkOutput("b2b_second", 11'b01111111110, 10, 161, 161);
      checkBit("b2b_gap_high", cap_serial[161], 1'b1);
      checkBit("b2b_second_start", cap_serial[162], 1'b0);
      checkInt("b2b_done_count", countDone(340), 2);

      $display("[TB] bus change and valid pulse mid-frame are ignored");
      applyStimulus(0, 8'h55, 8'hAA, 50, 1, 50, 200);
      checkOutput("ignore", 11'b01010101010, 10, 0, 161);
      cnt = 0;
      for (int k = 162; k <= 200; k++) begin
         if (cap_serial[k] !== 1'b1 || cap_active[k] !== 1'b0) cnt++;
      end
      checkInt("ignore_no_second_frame", cnt, 0);
      checkInt("ignore_done_count", countDone(200), 1);

      $display("[TB] reset during data bit 3");
      @(negedge clk);
      bus_drv[0]   = 8'h00;
      valid_drv[0] = 1'b1;
      @(negedge clk);
      valid_drv[0] = 1'b0;
      repeat (69) @(negedge clk);
      checkBit("rst_pre_active", active_mon[0], 1'b1);
      checkBit("rst_pre_serial", ser_mon[0], 1'b0);
      rst_n = 1'b0;
      #1;
      checkBit("rst_serial_high", ser_mon[0], 1'b1);
      checkBit("rst_ready_high", ready_mon[0], 1'b1);
      checkBit("rst_active_low", active_mon[0], 1'b0);
      done_seen = 0;
      for (int k = 0; k < 3; k++) begin
         @(negedge clk);
         if (done_mon[0] === 1'b1) done_seen++;
      end
      rst_n = 1'b1;
      cnt = 0;
      for (int k = 0; k < 40; k++) begin
         @(negedge clk);
         if (done_mon[0] === 1'b1) done_seen++;
         if (ser_mon[0] !== 1'b1) cnt++;
      end
      checkInt("rst_no_done", done_seen, 0);
      checkInt("rst_line_stays_high", cnt, 0);

      $display("[TB] fresh frame after reset");
      runVector(4);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/uart_tx.md
Name: uart_tx

Overview:
- UART transmitter; serialises a BUS_WIDTH-bit parallel word onto one line as start bit, data LSB first, optional parity, then 1 or 2 stop bits.
- Sits between the host-side data path and the board TX pin.
- Pairs with the UART receiver already in the UART module.
- Uses a valid/ready handshake on the parallel side, plus busy and done status outputs.

Parameters:
- BAUD_RATE, 115200, line bit rate in bits/s.
- CLK_FREQ, 300000000, i_clk frequency in Hz.
- BUS_WIDTH, 8, data bits per frame (5..9).
- PARITY, 0, 0 = none, 1 = odd, 2 = even; value 3 treated as none.
- STOP_BITS, 1, number of stop bits (1 or 2).
- CLK_PER_BIT, CLK_FREQ/BAUD_RATE (integer division, 2604 at defaults), i_clk cycles per bit; must be >= 2.

Ports:
- i_clk  input  1  system clock, all logic on rising edge.
- i_rst_n  input  1  asynchronous active-low reset.
- i_tx_bus  input  BUS_WIDTH  word to transmit; sampled only on an accepted handshake.
- i_tx_valid  input  1  host has a word on i_tx_bus.
- o_tx_ready  output  1  block can accept a word this cycle.
- o_tx_serial  output  1  serial line, idle high; registered output.
- o_tx_active  output  1  high while a frame is being driven.
- o_tx_done  output  1  single-cycle pulse after the final stop bit completes.

Behaviour:
- Reset (i_rst_n low, asynchronous) forces:
  - o_tx_serial = 1, o_tx_ready = 1, o_tx_active = 0, o_tx_done = 0;
  - state = IDLE, bit counter = 0, bit index = 0, shift register = 0.
- Reset mid-frame aborts the frame immediately: the line goes high and no done pulse is produced.
- States: IDLE, START, DATA, PARITY, STOP.
- IDLE:
  - o_tx_ready = 1, o_tx_serial = 1, o_tx_active = 0.
  - An accept happens in cycle T when i_tx_valid & o_tx_ready.
  - On the T edge: latch i_tx_bus into the shift register, compute the parity bit, clear the counter, go to START.
- START: o_tx_serial = 0 for CLK_PER_BIT cycles (T+1 .. T+CLK_PER_BIT), then go to DATA with bit index 0.
- DATA:
  - o_tx_serial = latched bit[index] for CLK_PER_BIT cycles; LSB first.
  - After bit BUS_WIDTH-1, go to PARITY if PARITY is 1 or 2, else to STOP.
- PARITY:
  - Even: bit = XOR of the latched word. Odd: bit = inverted XOR.
  - Held for CLK_PER_BIT cycles, then go to STOP.
- STOP: o_tx_serial = 1 for STOP_BITS*CLK_PER_BIT cycles.
- End of frame:
  - On the edge ending the last stop cycle, go to IDLE and set o_tx_done = 1 for exactly one cycle.
  - Frame length F = CLK_PER_BIT*(1 + BUS_WIDTH + (PARITY?1:0) + STOP_BITS).
  - o_tx_done is high in cycle T+F+1; o_tx_ready is also 1 in that cycle.
- Outside IDLE: o_tx_ready = 0 and o_tx_active = 1.
  - i_tx_valid and i_tx_bus are ignored; a changing i_tx_bus must not affect the frame in flight.
- Back-to-back:
  - If i_tx_valid is held high, the next accept occurs in cycle T+F+1 and the next start bit begins at T+F+2.
  - Exactly one extra idle-high cycle lies between frames.
- Bit counter:
  - Width $clog2(CLK_PER_BIT), counts 0..CLK_PER_BIT-1 and wraps.
  - Bit transitions occur only on wrap; no drift across a frame.
- Bit index width is $clog2(BUS_WIDTH); it must not overflow at BUS_WIDTH-1.
- o_tx_serial comes straight from a flop and is never glitchy or combinational.

Test Plan:
(Bench overrides CLK_FREQ=1600000, BAUD_RATE=100000, so CLK_PER_BIT=16.)
- Defaults, send 0xA5 accepted at cycle T.
  - Required: line sampled at bit centres (T+8+16k) reads 0,1,0,1,0,0,1,0,1,1.
  - o_tx_done high only at T+161; o_tx_ready low T+1..T+160.
- PARITY=2, send 0x07 → parity bit = 1. PARITY=1, send 0x07 → parity bit = 0.
  - In both cases the frame is 176 cycles and done is at T+177.
- STOP_BITS=2, send 0x3C → line high for 32 cycles after bit 7, done at T+177.
- Back-to-back 0x00 then 0xFF with i_tx_valid held.
  - Required: exactly one high cycle between the first frame's stop and the second start.
  - Second frame decodes to 0xFF; two done pulses, 161 cycles apart.
- Send 0x55, then toggle i_tx_bus to 0xAA and pulse i_tx_valid during DATA bit 2.
  - Required: transmitted word stays 0x55, ready stays 0, no second frame starts.
- Assert i_rst_n low during DATA bit 3.
  - Required: o_tx_serial = 1 within the same cycle, o_tx_ready = 1, o_tx_active = 0, no done pulse.
  - After release, a fresh 0x81 frame is bit-exact.
